alu_cmd_sequencer: RTL

Upstream command stage for the 8-bit ALU core.
- Buffers operand/mode commands in a small FIFO and issues them one at a time on the ALU's a/b/mode inputs, pulsing alu_start.
- Waits for the ALU's done, captures op1/op2/op3, and returns them on a valid/ready response port.
- Decouples a variable-latency ALU from the requesting logic.

---
 rtl/alu_cmd_sequencer_if.sv | 26 ++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle for alu_cmd_sequencer.
// The master modport is the requesting logic; the slave modport is the sequencer.
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_op1;
    logic [7:0]  rsp_op2;
    logic [15:0] rsp_op3;
    logic [2:0]  rsp_mode;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_mode, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_mode, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/wait/response sequencer in front of a variable-latency 8-bit ALU.
// Define ALU_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err=1 on expiry.
module alu_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_cmd_sequencer_if.slave       bus,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_mode,
    output logic                     alu_start,
    input  logic                     alu_done,
    input  logic [7:0]               alu_op1,
    input  logic [7:0]               alu_op2,
    input  logic [15:0]              alu_op3,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("alu_cmd_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop, timeout;

    // cmd_ready looks only at the registered count, so a pop never frees a slot in the same cycle
    assign full          = (cmd_count == (AW + 1)'(DEPTH));
    assign empty         = (cmd_count == '0);
    assign bus.cmd_ready = !full;
    assign push          = bus.cmd_valid && !full;
    assign pop           = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cmd_mode, bus.cmd_b, bus.cmd_a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cmd_count <= cmd_count + 1'b1;
            else if (pop && !push) cmd_count <= cmd_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // alu_done is not looked at in ISSUE: it may still be high from the previous operation
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (alu_done || timeout) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign alu_start     = (state == ISSUE);
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_mode     <= '0;
            bus.rsp_op1  <= '0;
            bus.rsp_op2  <= '0;
            bus.rsp_op3  <= '0;
            bus.rsp_mode <= '0;
        end else begin
            if (pop) {alu_mode, alu_b, alu_a} <= mem[rd_ptr];
            if (state == WAIT) begin
                if (alu_done) begin
                    bus.rsp_op1  <= alu_op1;
                    bus.rsp_op2  <= alu_op2;
                    bus.rsp_op3  <= alu_op3;
                    bus.rsp_mode <= alu_mode;
                end else if (timeout) begin
                    bus.rsp_op1  <= '0;
                    bus.rsp_op2  <= '0;
                    bus.rsp_op3  <= '0;
                    bus.rsp_mode <= alu_mode;
                end
            end
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    // counter holds the number of completed WAIT cycles; expiry ends the TIMEOUT_CYCLES-th one
    assign timeout = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tmo_cnt <= '0;
        else if (state == ISSUE)  tmo_cnt <= '0;
        else if (state == WAIT)   tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        bus.rsp_err <= 1'b0;
        else if (state == WAIT && (alu_done || timeout))   bus.rsp_err <= !alu_done;
    end
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif
endmodule
